// File: rtl/sram_pixel_streamer.sv
// SRAM read streamer: sequential word reads unpacked into a 4-bit pixel stream.
// Optional SRAM_STREAM_TRANSPARENT_EN adds o_pix_opaque (pixel != 0).
module sram_pixel_streamer #(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 16,
    parameter int PIXEL_WIDTH  = 4,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH-1:0]  i_base_addr,
    input  logic [ADDR_WIDTH-1:0]  i_word_count,
    input  logic                   i_abort,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_sram_rd,
    output logic [ADDR_WIDTH-1:0]  o_sram_addr,
    input  logic [DATA_WIDTH-1:0]  i_sram_rdata,
    output logic                   o_pix_valid,
    input  logic                   i_pix_ready,
    output logic [PIXEL_WIDTH-1:0] o_pix,
    output logic                   o_pix_last
`ifdef SRAM_STREAM_TRANSPARENT_EN
    ,
    output logic                   o_pix_opaque
`endif
);

    localparam int NPW = DATA_WIDTH / PIXEL_WIDTH;
    localparam int IW  = (NPW > 1) ? $clog2(NPW) : 1;
    localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [IW-1:0]  IDX_MAX = IW'(NPW - 1);
    localparam logic [FAW-1:0] PTR_MAX = FAW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_q, rd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   left_q, left_d;
    logic [ADDR_WIDTH-1:0]   words_q, words_d;
    logic [READ_LATENCY-1:0] tag_q, tag_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [FAW-1:0]          wp_q, wp_d;
    logic [FAW-1:0]          rp_q, rp_d;
    logic [CW-1:0]           fcnt_q, fcnt_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    valid_q, valid_d;
    logic                    lastw_q, lastw_d;
    logic [PIXEL_WIDTH-1:0]  pix_q, pix_d;
    logic                    last_q, last_d;

    logic hs, need, pop, byp, push, consume, credit_ok;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        left_d  = left_q;
        words_d = words_q;
        tag_d   = tag_q << 1;
        tag_d[0] = rd_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        word_d  = word_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        lastw_d = lastw_q;
        pop     = 1'b0;
        byp     = 1'b0;

        // Unpacker: refill from FIFO head, or straight from the SRAM return
        hs   = valid_q & i_pix_ready;
        need = ~valid_q | (hs & (idx_q == IDX_MAX));
        if (hs && idx_q != IDX_MAX)
            idx_d = idx_q + 1'b1;
        if (need) begin
            valid_d = 1'b0;
            if (fcnt_q != '0)
                pop = 1'b1;
            else if (tag_q[READ_LATENCY-1])
                byp = 1'b1;
            if (pop || byp) begin
                word_d  = pop ? mem_q[rp_q] : i_sram_rdata;
                valid_d = 1'b1;
                idx_d   = '0;
                lastw_d = (words_q == ADDR_WIDTH'(1));
                words_d = words_q - 1'b1;
            end
        end
        push    = tag_q[READ_LATENCY-1] & ~byp;
        consume = pop | byp;

        // Credits cover reads in flight plus words still queued in the FIFO
        credit_ok = int'(cnt_q) < FIFO_DEPTH + int'(consume);

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        rd_d    = 1'b1;
                        addr_d  = i_base_addr;
                        left_d  = i_word_count - 1'b1;
                        words_d = i_word_count;
                    end
                end
            end
            S_RUN: begin
                if (left_q == '0) begin
                    state_d = S_DRAIN;
                end else if (credit_ok) begin
                    rd_d   = 1'b1;
                    addr_d = addr_q + 1'b1;
                    left_d = left_q - 1'b1;
                end
            end
            S_DRAIN: begin
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && hs && last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end

        if (push)
            wp_d = (wp_q == PTR_MAX) ? '0 : wp_q + 1'b1;
        if (pop)
            rp_d = (rp_q == PTR_MAX) ? '0 : rp_q + 1'b1;
        fcnt_d = fcnt_q + CW'(push) - CW'(pop);
        cnt_d  = cnt_q + CW'(rd_d) - CW'(consume);

        if (i_abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            rd_d    = 1'b0;
            left_d  = '0;
            words_d = '0;
            tag_d   = '0;
            wp_d    = '0;
            rp_d    = '0;
            fcnt_d  = '0;
            cnt_d   = '0;
            word_d  = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            lastw_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
        pix_d  = '0;
        for (int k = 0; k < NPW; k++) begin
            if (idx_d == IW'(k))
                pix_d = word_d[DATA_WIDTH-1-k*PIXEL_WIDTH -: PIXEL_WIDTH];
        end
        if (!valid_d)
            pix_d = '0;
        last_d = valid_d & lastw_d & (idx_d == IDX_MAX);
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem_q[wp_q] <= i_sram_rdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            left_q  <= '0;
            words_q <= '0;
            tag_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            fcnt_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            lastw_q <= 1'b0;
            pix_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            words_q <= words_d;
            tag_q   <= tag_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            lastw_q <= lastw_d;
            pix_q   <= pix_d;
            last_q  <= last_d;
        end
    end

`ifdef SRAM_STREAM_TRANSPARENT_EN
    logic opaque_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            opaque_q <= 1'b0;
        else
            opaque_q <= (pix_d != '0);
    end

    assign o_pix_opaque = opaque_q;
`endif

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_sram_rd   = rd_q;
    assign o_sram_addr = addr_q;
    assign o_pix_valid = valid_q;
    assign o_pix       = pix_q;
    assign o_pix_last  = last_q;

endmodule

// File: tb/tb_sram_pixel_streamer.sv
// Randomized self-checking bench for sram_pixel_streamer.
// Reference model: expected pixel/address streams built from the word list.
module tb_sram_pixel_streamer;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [19:0] base = '0;
    logic [19:0] count = '0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic [15:0] rdata = '0;
    logic        busy, done, sram_rd, pix_valid, pix_last;
    logic [19:0] sram_addr;
    logic [3:0]  pix;
`ifdef SRAM_STREAM_TRANSPARENT_EN
    logic        opaque;
    logic        opq_log[$];
`endif

    sram_pixel_streamer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_base_addr  (base),
        .i_word_count (count),
        .i_abort      (abort),
        .o_busy       (busy),
        .o_done       (done),
        .o_sram_rd    (sram_rd),
        .o_sram_addr  (sram_addr),
        .i_sram_rdata (rdata),
        .o_pix_valid  (pix_valid),
        .i_pix_ready  (ready),
        .o_pix        (pix),
        .o_pix_last   (pix_last)
`ifdef SRAM_STREAM_TRANSPARENT_EN
        ,
        .o_pix_opaque (opaque)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [19:0] addr;
    } rq_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int ready_pct = 100;
    logic [15:0] mem [logic [19:0]];
    rq_t         pend[$];
    logic [4:0]  pix_log[$];
    int          pix_cyc[$];
    logic [19:0] rd_log[$];
    int          rd_cyc[$];
    int          done_cyc[$];
    logic [4:0]  exp_pix[$];
    logic [19:0] exp_rd[$];
    int issued, hs_total, max_out, stall_viol, busy_seen;
    logic pv, pr;
    logic [4:0] pp;

    function automatic logic [15:0] mem_rd(input logic [19:0] a);
        logic [15:0] d;
        d = 16'hDEAD;
        if (mem.exists(a))
            d = mem[a];
        return d;
    endfunction

    task automatic clear_logs();
        pix_log.delete();
        pix_cyc.delete();
        rd_log.delete();
        rd_cyc.delete();
        done_cyc.delete();
`ifdef SRAM_STREAM_TRANSPARENT_EN
        opq_log.delete();
`endif
        issued = 0;
        hs_total = 0;
        max_out = 0;
        stall_viol = 0;
        busy_seen = 0;
        pv = 1'b0;
        pr = 1'b0;
        pp = '0;
    endtask

    // One clock cycle: SRAM model, consumer, observation logs
    task automatic step();
        int o;
        rdata = 16'($urandom);
        while (pend.size() > 0 && pend[0].due < cyc)
            void'(pend.pop_front());
        if (pend.size() > 0 && pend[0].due == cyc) begin
            rdata = mem_rd(pend[0].addr);
            void'(pend.pop_front());
        end
        if (sram_rd) begin
            pend.push_back('{cyc + L, sram_addr});
            rd_log.push_back(sram_addr);
            rd_cyc.push_back(cyc);
            issued++;
        end
        ready = ($urandom_range(99) < ready_pct);
        if (pv && !pr && !(pix_valid && {pix_last, pix} == pp))
            stall_viol++;
        o = issued - hs_total / 4;
        if (o > max_out)
            max_out = o;
        if (pix_valid && ready) begin
            pix_log.push_back({pix_last, pix});
            pix_cyc.push_back(cyc);
            hs_total++;
`ifdef SRAM_STREAM_TRANSPARENT_EN
            opq_log.push_back(opaque);
`endif
        end
        if (done)
            done_cyc.push_back(cyc);
        if (busy)
            busy_seen = 1;
        pv = pix_valid;
        pr = ready;
        pp = {pix_last, pix};
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic build_expect(input logic [19:0] b, input int n);
        logic [19:0] a;
        logic [15:0] d;
        logic [3:0]  nb;
        exp_pix.delete();
        exp_rd.delete();
        for (int w = 0; w < n; w++) begin
            a = b + 20'(w);
            exp_rd.push_back(a);
            d = mem_rd(a);
            for (int k = 0; k < 4; k++) begin
                nb = 4'(d >> (12 - 4 * k));
                exp_pix.push_back({(w == n - 1 && k == 3), nb});
            end
        end
    endtask

    function automatic int pix_diff();
        if (pix_log.size() != exp_pix.size())
            return pix_log.size();
        foreach (exp_pix[i])
            if (pix_log[i] !== exp_pix[i])
                return i;
        return -1;
    endfunction

    function automatic int rd_diff();
        if (rd_log.size() != exp_rd.size())
            return rd_log.size();
        foreach (exp_rd[i])
            if (rd_log[i] !== exp_rd[i])
                return i;
        return -1;
    endfunction

    task automatic run_transfer(input logic [19:0] b, input logic [19:0] n,
                                input int pct, input int restart_at);
        clear_logs();
        t0 = cyc;
        ready_pct = pct;
        base = b;
        count = n;
        start = 1'b1;
        step();
        start = 1'b0;
        while (done_cyc.size() == 0 && cyc - t0 < 600) begin
            if (cyc - t0 == restart_at) begin
                base = 20'h55555;
                count = 20'd2;
                start = 1'b1;
            end
            step();
            start = 1'b0;
        end
        repeat (6) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, sram_rd, pix_valid, pix_last} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {busy, done, sram_rd, pix_valid, pix_last});
        end
        checks++;
        if ({sram_addr, pix} !== 24'h0) begin
            failures++;
            $display("FAIL reset_data got %h want 000000", {sram_addr, pix});
        end
`ifdef SRAM_STREAM_TRANSPARENT_EN
        checks++;
        if (opaque !== 1'b0) begin
            failures++;
            $display("FAIL reset_opaque got %b want 0", opaque);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        int e, fc;
        mem.delete();
        mem[20'h0] = 16'hABCD;
        build_expect(20'h0, 1);
        run_transfer(20'h0, 20'd1, 100, -1);
        checks++;
        e = rd_diff();
        if (e !== -1 || rd_cyc.size() != 1 || rd_cyc[0] - t0 != 1) begin
            failures++;
            $display("FAIL single_read reads=%0d first_cycle=%0d want 1 read at cycle 1",
                     rd_log.size(), rd_cyc.size() ? rd_cyc[0] - t0 : -1);
        end
        checks++;
        e = pix_diff();
        if (e !== -1) begin
            failures++;
            $display("FAIL single_pixels idx=%0d got %h want %h", e,
                     (e < pix_log.size()) ? pix_log[e] : 5'h1f,
                     (e < exp_pix.size()) ? exp_pix[e] : 5'h1f);
        end
        checks++;
        fc = pix_cyc.size() ? pix_cyc[0] - t0 : -1;
        if (fc != 4 || pix_cyc.size() != 4 || pix_cyc[3] - t0 != 7) begin
            failures++;
            $display("FAIL single_pix_timing first=%0d want 4 count=%0d want 4",
                     fc, pix_cyc.size());
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] - t0 != 8) begin
            failures++;
            $display("FAIL single_done pulses=%0d cycle=%0d want 1 at 8", done_cyc.size(),
                     done_cyc.size() ? done_cyc[0] - t0 : -1);
        end
    endtask

    task automatic test_zero_count();
        run_transfer(20'h12345, 20'd0, 100, -1);
        checks++;
        if (rd_log.size() != 0) begin
            failures++;
            $display("FAIL zero_reads got %0d want 0", rd_log.size());
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] - t0 != 1) begin
            failures++;
            $display("FAIL zero_done pulses=%0d cycle=%0d want 1 at 1", done_cyc.size(),
                     done_cyc.size() ? done_cyc[0] - t0 : -1);
        end
        checks++;
        if (busy_seen != 0) begin
            failures++;
            $display("FAIL zero_busy got %0d want 0", busy_seen);
        end
    endtask

    task automatic test_backpressure();
        int e;
        mem.delete();
        for (int w = 0; w < 8; w++)
            mem[20'(w)] = 16'($urandom);
        build_expect(20'h0, 8);
        run_transfer(20'h0, 20'd8, 30, 3);
        checks++;
        e = rd_diff();
        if (e !== -1) begin
            failures++;
            $display("FAIL bp_reads idx=%0d got %0d reads want 8 consecutive from 0",
                     e, rd_log.size());
        end
        checks++;
        e = pix_diff();
        if (e !== -1) begin
            failures++;
            $display("FAIL bp_pixels idx=%0d got %0d pixels want 32", e, pix_log.size());
        end
        checks++;
        if (max_out > 5) begin
            failures++;
            $display("FAIL bp_credit outstanding=%0d want <=5", max_out);
        end
        checks++;
        if (stall_viol != 0) begin
            failures++;
            $display("FAIL bp_stall_hold changes=%0d want 0", stall_viol);
        end
        checks++;
        if (done_cyc.size() != 1) begin
            failures++;
            $display("FAIL bp_done pulses=%0d want 1", done_cyc.size());
        end
    endtask

    task automatic test_wrap();
        int e;
        mem.delete();
        for (int w = 0; w < 4; w++)
            mem[20'hFFFFE + 20'(w)] = 16'($urandom);
        build_expect(20'hFFFFE, 4);
        run_transfer(20'hFFFFE, 20'd4, 70, -1);
        checks++;
        e = rd_diff();
        if (e !== -1) begin
            failures++;
            $display("FAIL wrap_reads idx=%0d got %h want %h", e,
                     (e < rd_log.size()) ? rd_log[e] : 20'hxxxxx,
                     (e < exp_rd.size()) ? exp_rd[e] : 20'hxxxxx);
        end
        checks++;
        e = pix_diff();
        if (e !== -1) begin
            failures++;
            $display("FAIL wrap_pixels idx=%0d got %0d pixels want 16", e, pix_log.size());
        end
        checks++;
        if (done_cyc.size() != 1) begin
            failures++;
            $display("FAIL wrap_done pulses=%0d want 1", done_cyc.size());
        end
    endtask

    task automatic test_back_to_back();
        int e, span;
        logic [19:0] b;
        b = 20'($urandom);
        mem.delete();
        for (int w = 0; w < 6; w++)
            mem[b + 20'(w)] = 16'($urandom);
        build_expect(b, 6);
        run_transfer(b, 20'd6, 100, -1);
        checks++;
        e = pix_diff();
        if (e !== -1) begin
            failures++;
            $display("FAIL b2b_pixels idx=%0d got %0d pixels want 24", e, pix_log.size());
        end
        checks++;
        span = pix_cyc.size() ? pix_cyc[pix_cyc.size() - 1] - pix_cyc[0] : -1;
        if (span != 23) begin
            failures++;
            $display("FAIL b2b_bubbles span=%0d want 23", span);
        end
        checks++;
        if (pix_cyc.size() == 0 || pix_cyc[0] - t0 != 4) begin
            failures++;
            $display("FAIL b2b_first got %0d want 4",
                     pix_cyc.size() ? pix_cyc[0] - t0 : -1);
        end
    endtask

    task automatic test_abort();
        int e;
        mem.delete();
        for (int w = 0; w < 16; w++)
            mem[20'(w)] = 16'($urandom);
        clear_logs();
        t0 = cyc;
        ready_pct = 50;
        base = 20'h0;
        count = 20'd16;
        start = 1'b1;
        step();
        start = 1'b0;
        while (cyc - t0 < 6)
            step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({pix_valid, busy, sram_rd, done} !== 4'b0) begin
            failures++;
            $display("FAIL abort_flush got %b want 0000", {pix_valid, busy, sram_rd, done});
        end
        mem[20'h100] = 16'h1234;
        build_expect(20'h100, 1);
        run_transfer(20'h100, 20'd1, 100, -1);
        checks++;
        e = pix_diff();
        if (e !== -1) begin
            failures++;
            $display("FAIL abort_restart_pixels idx=%0d got %0d pixels want 1,2,3,4",
                     e, pix_log.size());
        end
        checks++;
        if (done_cyc.size() != 1) begin
            failures++;
            $display("FAIL abort_done pulses=%0d want 1", done_cyc.size());
        end
    endtask

    task automatic test_async_reset();
        mem.delete();
        clear_logs();
        ready_pct = 100;
        base = 20'h0;
        count = 20'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        checks++;
        if (busy !== 1'b1 || pix_valid !== 1'b1) begin
            failures++;
            $display("FAIL async_pre got busy=%b valid=%b want 1 1", busy, pix_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, sram_rd, pix_valid, pix_last, pix, sram_addr} !== 28'h0) begin
            failures++;
            $display("FAIL async_reset got %h want 0",
                     {busy, sram_rd, pix_valid, pix_last, pix, sram_addr});
        end
        @(negedge clk);
        rst_n = 1'b1;
        pend.delete();
        @(negedge clk);
        cyc += 2;
    endtask

`ifdef SRAM_STREAM_TRANSPARENT_EN
    task automatic test_opaque();
        mem.delete();
        mem[20'h200] = 16'h0F00;
        run_transfer(20'h200, 20'd1, 100, -1);
        checks++;
        if (opq_log.size() != 4 || {opq_log[0], opq_log[1], opq_log[2], opq_log[3]} !== 4'b0100) begin
            failures++;
            $display("FAIL opaque_seq n=%0d want 4 pixels with 0100", opq_log.size());
        end
    endtask
`endif

    initial begin
        #1 rst_n = 1'b0;
        test_reset();
        test_single_word();
        test_zero_count();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_async_reset();
`ifdef SRAM_STREAM_TRANSPARENT_EN
        test_opaque();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
